// File: rtl/masked_chi_row_sequencer.sv
// Feeds a two-share masked state row by row into an external masked chi core and
// reassembles the result shares. The share0 and share1 datapaths never meet.
module masked_chi_row_sequencer #(
   parameter int CHI_LATENCY = 3,
   parameter int ROWS        = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [5*ROWS-1:0]   in_share0,
   input  logic [5*ROWS-1:0]   in_share1,
   input  logic [ROWS-1:0]     in_rand,
   output logic [4:0]          core_share0_out,
   output logic [4:0]          core_share1_out,
   output logic                core_rand,
   input  logic [4:0]          core_share0_res,
   input  logic [4:0]          core_share1_res,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [5*ROWS-1:0]   out_share0,
   output logic [5*ROWS-1:0]   out_share1
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int L  = CHI_LATENCY;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

   state_e                    state_q, state_d;
   logic [ROWS-1:0][4:0]      s0_q, s0_d, s1_q, s1_d;
   logic [ROWS-1:0][4:0]      o0_q, o0_d, o1_q, o1_d;
   logic [ROWS-1:0]           rnd_q, rnd_d;
   logic [RW-1:0]             row_q, row_d;
   logic [L-1:0]              pv_q, pv_d;
   logic [L-1:0][RW-1:0]      pidx_q, pidx_d;
   logic                      last_cap;

   // Tail of the tag pipe lines up with the core result of the row it tracks.
   assign last_cap = pv_q[L-1] && (pidx_q[L-1] == RW'(ROWS-1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (in_valid) state_d = FEED;
         FEED:  if (last_cap) state_d = DONE;
                else if (row_q == RW'(ROWS-1)) state_d = DRAIN;
         DRAIN: if (last_cap) state_d = DONE;
         DONE:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready        = (state_q == IDLE);
      out_valid       = (state_q == DONE);
      core_share0_out = '0;
      core_share1_out = '0;
      core_rand       = 1'b0;
      if (state_q == FEED) begin
         core_share0_out = s0_q[row_q];
         core_share1_out = s1_q[row_q];
         core_rand       = rnd_q[row_q];
      end
   end

   always_comb begin
      s0_d   = s0_q;
      s1_d   = s1_q;
      rnd_d  = rnd_q;
      o0_d   = o0_q;
      o1_d   = o1_q;
      row_d  = '0;
      pv_d   = '0;
      pidx_d = '0;
      if (state_q == IDLE && in_valid) begin
         s0_d  = in_share0;
         s1_d  = in_share1;
         rnd_d = in_rand;
      end
      // Input shares are wiped as soon as the last row has been handed to the core.
      if (state_q == FEED) begin
         if (state_d == FEED) row_d = row_q + RW'(1);
         else begin
            s0_d  = '0;
            s1_d  = '0;
            rnd_d = '0;
         end
      end
      if (pv_q[L-1]) begin
         o0_d[pidx_q[L-1]] = core_share0_res;
         o1_d[pidx_q[L-1]] = core_share1_res;
      end
      if (state_q == DONE && out_ready) begin
         o0_d = '0;
         o1_d = '0;
      end
      pv_d[0]   = (state_d == FEED);
      pidx_d[0] = row_d;
      for (int i = 1; i < L; i++) begin
         pv_d[i]   = pv_q[i-1];
         pidx_d[i] = pidx_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_q   <= '0;
         s1_q   <= '0;
         rnd_q  <= '0;
         o0_q   <= '0;
         o1_q   <= '0;
         row_q  <= '0;
         pv_q   <= '0;
         pidx_q <= '0;
      end else begin
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         rnd_q  <= rnd_d;
         o0_q   <= o0_d;
         o1_q   <= o1_d;
         row_q  <= row_d;
         pv_q   <= pv_d;
         pidx_q <= pidx_d;
      end
   end

   assign out_share0 = o0_q;
   assign out_share1 = o1_q;

endmodule

// File: doc/masked_chi_row_sequencer.md
MASKED_CHI_ROW_SEQUENCER -- requirements
Module: masked_chi_row_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 Parameter CHI_LATENCY, default 3: cycles from a row presented on core_share*_out to its result on core_share*_res; legal range 1..7.
REQ-003 Parameter ROWS, default 5: rows per state; row r occupies bits [5r+4:5r].
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  input state offered.
REQ-007 in_ready  out  1  block accepts a state.
REQ-008 in_share0, in_share1  in  5*ROWS each  the two Boolean shares of the input state.
REQ-009 in_rand  in  ROWS  one fresh random bit per row.
REQ-010 core_share0_out, core_share1_out  out  5 each  row shares driven to the masked chi core.
REQ-011 core_rand  out  1  random bit for the row currently driven.
REQ-012 core_share0_res, core_share1_res  in  5 each  chi core result shares.
REQ-013 out_valid  out  1  result state available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_share0, out_share1  out  5*ROWS each  result shares.

Function
REQ-016 The FSM SHALL have states IDLE, FEED, DRAIN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 On in_valid & in_ready at edge E0, the block SHALL register in_share0, in_share1 and in_rand, then enter FEED.
REQ-019 In FEED, a row counter SHALL advance 0..ROWS-1 by one per cycle.
  - Row r is driven on core_share*_out and in_rand[r] on core_rand between edges E(r) and E(r+1).
  - After row ROWS-1 the FSM enters DRAIN.
REQ-020 Outside FEED, core_share0_out, core_share1_out and core_rand SHALL be 0.
REQ-021 A CHI_LATENCY-deep shift register SHALL carry a valid bit and the row index for each fed row.
  - The result of row r is sampled at edge E(r+CHI_LATENCY) into bits [5r+4:5r] of the out_share0/out_share1 registers.
REQ-022 When the last row is captured, the FSM SHALL enter DONE and assert out_valid.
  - For default parameters this happens at E(ROWS+CHI_LATENCY-1), i.e. E7.
REQ-023 In DONE, out_valid and out_share* SHALL hold stable until out_ready is 1.
REQ-024 On out_valid & out_ready, the block SHALL clear the out_share* registers and return to IDLE.
  - in_ready is 1 in the following cycle.
  - Back-to-back throughput: one state per ROWS+CHI_LATENCY+1 cycles.
REQ-025 The registered input shares and random bits SHALL be cleared to 0 on leaving FEED.
  - Input shares are never held after use.
  - Input shares are never recombined: share0 and share1 data paths stay separate, with no gate mixing them.
REQ-026 in_valid while busy (FEED, DRAIN, DONE) SHALL be ignored, with no state or register change.
REQ-027 out_ready outside DONE SHALL have no effect.
REQ-028 If out_ready is already 1 on entry to DONE, out_valid SHALL be 1 for exactly one cycle.

Reset
REQ-029 While rst=1 at an edge, the FSM SHALL go to IDLE.
  - All share, random, row-counter and shift-register state is cleared to 0.
  - Reset has priority over every handshake.
REQ-030 Reset values: in_ready=1, out_valid=0, out_share0=out_share1=0, core_share*_out=0, core_rand=0.
REQ-031 rst asserted mid-FEED or mid-DRAIN SHALL abort the state with no out_valid pulse.
  - Results still emerging from the core afterwards are discarded.

Verification
REQ-032 The bench SHALL use a behavioural core stub: a CHI_LATENCY-cycle delay with result = input row.
  - Use in_share0=25'h0AAAAAA and in_share1=25'h1555555; out_valid must rise at E7.
  - The outputs must equal the inputs bit-for-bit.
REQ-033 The bench SHALL use a golden masked-chi model.
  - Use in_share0=25'h1234567, in_share1=25'h1234567 ^ 25'h1FFFFFF; out_share0^out_share1 must be 25'h1FFFFFF.
  - Use share XOR 25'h0; the recombined output must be 25'h0.
REQ-034 in_rand=5'b10110: core_rand must show 0,1,1,0,1 on consecutive FEED cycles, while core_share*_out show rows 0..4 in order.
REQ-035 Hold out_ready=0 for 10 cycles in DONE and pulse in_valid during FEED and DONE.
  - The outputs must stay stable, the second state must not be accepted, and in_ready must rise one cycle after the out handshake.
REQ-036 Assert rst at E3 of FEED.
  - From the next cycle all outputs are at reset values, out_valid never pulses, and a new state accepted afterwards completes correctly.
